// File: rtl/zipdma_wbmem_pkg.sv
// Shared types for the zipdma_wbmem Wishbone memory responder.
// One response-pipeline stage record is shared by the top and its documentation.
package zipdma_wbmem_pkg;

  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } resp_t;

  localparam int unsigned MIN_LATENCY = 1;
  localparam int unsigned MAX_LATENCY = 4;

endpackage

// File: rtl/zipdma_wbmem_if.sv
// Pipelined Wishbone B4 bus bundle between the DMA master and the memory responder.
// hold is a test/backpressure input that the responder reflects on stall.
interface zipdma_wbmem_if #(
  parameter int BUS_WIDTH = 512,
  parameter int AW        = 24
);
  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [AW-1:0]          addr;
  logic [BUS_WIDTH-1:0]   wdata;
  logic [BUS_WIDTH/8-1:0] sel;
  logic                   hold;
  logic                   stall;
  logic                   ack;
  logic                   err;
  logic [BUS_WIDTH-1:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel, hold,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel, hold,
    output stall, ack, err, rdata
  );
endinterface

// File: rtl/zipdma_wbmem_ram.sv
// Byte-enabled single-port block RAM with a registered read port.
// A read in cycle N sees every write committed in cycle N-1 or earlier.
module zipdma_wbmem_ram #(
  parameter int DW   = 512,
  parameter int LGSZ = 10
) (
  input  logic            i_clk,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [DW/8-1:0] sel,
  input  logic [LGSZ-1:0] addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [1<<LGSZ];

  // NOTE: the array has no reset branch; a reset loop would stop block RAM inference.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int k = 0; k < DW/8; k++) begin
        if (sel[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/zipdma_wbmem.sv
// Pipelined Wishbone B4 memory responder: fixed-latency reads, byte-lane writes,
// out-of-range bus error, cycle abort and injected backpressure.
module zipdma_wbmem
  import zipdma_wbmem_pkg::*;
#(
  parameter int BUS_WIDTH    = 512,
  parameter int AW           = 24,
  parameter int LGMEMSZ      = 10,
  parameter int LATENCY      = 2,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  zipdma_wbmem_if.slave  bus
);

  logic                 accept;
  logic                 in_range;
  logic                 wr_en;
  logic                 rd_en;
  logic                 live;
  logic [BUS_WIDTH-1:0] rd_q;
  logic [BUS_WIDTH-1:0] data_last;
  resp_t                pipe [LATENCY];
  resp_t                last;

  assign bus.stall = bus.hold;
  assign accept    = i_reset_n & bus.cyc & bus.stb & !bus.hold;

  generate
    if (LGMEMSZ < AW) begin : g_range
      assign in_range = (bus.addr[AW-1:LGMEMSZ] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign wr_en = accept & in_range & bus.we;
  assign rd_en = accept & in_range & !bus.we;

  zipdma_wbmem_ram #(
    .DW   (BUS_WIDTH),
    .LGSZ (LGMEMSZ)
  ) u_ram (
    .i_clk (i_clk),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .sel   (bus.sel),
    .addr  (bus.addr[LGMEMSZ-1:0]),
    .wdata (bus.wdata),
    .rdata (rd_q)
  );

  // Dropping cyc (or reset) discards every in-flight response at this edge.
  // NOTE: state registers use <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !bus.cyc) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= resp_t'{valid: accept, err: !in_range, we: bus.we};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign data_last = rd_q;
    end else begin : g_hold
      logic [BUS_WIDTH-1:0] hold_q [LATENCY-1];

      // Data stages need no reset: the output mux below masks them.
      always_ff @(posedge i_clk) begin
        hold_q[0] <= rd_q;
        for (int i = 1; i < LATENCY-1; i++) hold_q[i] <= hold_q[i-1];
      end

      assign data_last = hold_q[LATENCY-2];
    end
  endgenerate

  // Gating by cyc keeps an aborted cycle's final response off the bus as well.
  assign last      = pipe[LATENCY-1];
  assign live      = i_reset_n & bus.cyc & last.valid;
  assign bus.ack   = live & !last.err;
  assign bus.err   = live & last.err;
  assign bus.rdata = (i_reset_n && (!OPT_LOWPOWER || (bus.ack && !last.we)))
                     ? data_last : '0;

endmodule

// File: tb/tb_zipdma_wbmem.sv
// Self-checking bench for zipdma_wbmem: directed table, multi-cycle corner sequences
// and randomized traffic scored against a queue-based memory model.
module tb_zipdma_wbmem;

  localparam int BW  = 512;
  localparam int AW  = 24;
  localparam int LG  = 10;
  localparam int LAT = 2;
  localparam int SW  = BW/8;

  typedef struct {
    int             due;
    logic           err;
    logic           we;
    logic [BW-1:0]  data;
  } exp_t;

  typedef struct {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  data;
    logic [SW-1:0]  sel;
    logic           exp_err;
    logic           chk_data;
    logic [BW-1:0]  exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  zipdma_wbmem_if #(.BUS_WIDTH(BW), .AW(AW)) bus ();

  zipdma_wbmem #(
    .BUS_WIDTH    (BW),
    .AW           (AW),
    .LGMEMSZ      (LG),
    .LATENCY      (LAT),
    .OPT_LOWPOWER (1'b0)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  int             edge_cnt = 0;
  int             acc_cnt = 0;
  int             resp_cnt = 0;
  exp_t           q[$];
  logic [BW-1:0]  mdl [1<<LG];
  logic           seen_any;
  logic           seen_ack;
  logic           seen_err;
  logic [BW-1:0]  seen_data;
  vec_t           tbl [10];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Mid-cycle comparison of the bus outputs against the scoreboard head.
  task automatic score();
    exp_t e;
    logic ev, ea, ee;
    ev = (q.size() > 0) && (q[0].due == edge_cnt);
    e  = '{due: 0, err: 1'b0, we: 1'b0, data: '0};
    if (ev) e = q.pop_front();
    ea = rst_n && bus.cyc && ev && !e.err;
    ee = rst_n && bus.cyc && ev && e.err;
    check("ack", BW'(bus.ack), BW'(ea));
    check("err", BW'(bus.err), BW'(ee));
    if (ea && !e.we) check("rdata", bus.rdata, e.data);
    if (!rst_n) check("reset_rdata", bus.rdata, '0);
    if (bus.ack || bus.err) begin
      resp_cnt++;
      seen_any  = 1'b1;
      seen_ack  = bus.ack;
      seen_err  = bus.err;
      seen_data = bus.rdata;
    end
  endtask

  // Behavioural effect of the request presented at this rising edge.
  task automatic model_edge();
    exp_t e;
    logic acc, inr;
    logic [LG-1:0] idx;
    acc = rst_n && bus.cyc && bus.stb && !bus.hold;
    if (!rst_n || !bus.cyc) q.delete();
    if (acc) begin
      inr    = (bus.addr < AW'(1 << LG));
      idx    = bus.addr[LG-1:0];
      e.due  = edge_cnt + LAT - 1;
      e.err  = !inr;
      e.we   = bus.we;
      e.data = mdl[idx];
      q.push_back(e);
      acc_cnt++;
      if (inr && bus.we) begin
        for (int k = 0; k < SW; k++)
          if (bus.sel[k]) mdl[idx][8*k +: 8] = bus.wdata[8*k +: 8];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    score();
    @(posedge clk);
    edge_cnt++;
    model_edge();
    #1;
  endtask

  task automatic req(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d,
                     input logic [SW-1:0] s);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.hold = 1'b0;
    bus.we = we; bus.addr = a; bus.wdata = d; bus.sel = s;
  endtask

  task automatic idle();
    bus.cyc = 1'b1; bus.stb = 1'b0; bus.we = 1'b0; bus.hold = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] d,
                      input logic [SW-1:0] s);
    seen_any = 1'b0;
    req(we, a, d, s);
    step();
    idle();
    for (int i = 0; i < 8 && !seen_any; i++) step();
    check("xact_response", BW'(seen_any), BW'(1'b1));
    step();
  endtask

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < BW/32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    int r0;
    int a0;
    logic [BW-1:0] rw;
    logic          rwe;
    logic [AW-1:0] ra;
    logic [SW-1:0] rs;
    logic          pending;
    int            accepted;

    for (int i = 0; i < (1 << LG); i++) mdl[i] = '0;

    tbl[0] = '{1'b1, 24'd5,    {SW{8'hFF}},             {SW{1'b1}}, 1'b0, 1'b0, '0};
    tbl[1] = '{1'b1, 24'd5,    {SW{8'h00}},             SW'('h0F),  1'b0, 1'b0, '0};
    tbl[2] = '{1'b0, 24'd5,    '0,                      '0,         1'b0, 1'b1, {{(SW-4){8'hFF}}, {4{8'h00}}}};
    tbl[3] = '{1'b1, 24'd0,    {16{32'hA5A5_0001}},     {SW{1'b1}}, 1'b0, 1'b0, '0};
    tbl[4] = '{1'b0, 24'd1024, '0,                      '0,         1'b1, 1'b0, '0};
    tbl[5] = '{1'b1, 24'd1024, {16{32'h5A5A_BEEF}},     {SW{1'b1}}, 1'b1, 1'b0, '0};
    tbl[6] = '{1'b0, 24'd0,    '0,                      '0,         1'b0, 1'b1, {16{32'hA5A5_0001}}};
    tbl[7] = '{1'b0, 24'hFFFFFF, '0,                    '0,         1'b1, 1'b0, '0};
    tbl[8] = '{1'b1, 24'd1023, {16{32'h1234_5678}},     {SW{1'b1}}, 1'b0, 1'b0, '0};
    tbl[9] = '{1'b0, 24'd1023, '0,                      '0,         1'b0, 1'b1, {16{32'h1234_5678}}};

    // Reset with an active write request: nothing may respond or commit.
    rst_n = 1'b0;
    req(1'b1, 24'd3, {16{32'hDEAD_BEEF}}, {SW{1'b1}});
    repeat (3) step();
    rst_n = 1'b1;
    idle();
    repeat (2) step();

    // Back-to-back burst write then burst read of words 0..7.
    r0 = resp_cnt;
    for (int a = 0; a < 8; a++) begin
      req(1'b1, AW'(a), {SW{8'(a)}}, {SW{1'b1}});
      step();
    end
    idle();
    repeat (4) step();
    check("burst_wr_acks", BW'(resp_cnt - r0), BW'(8));
    r0 = resp_cnt;
    for (int a = 0; a < 8; a++) begin
      req(1'b0, AW'(a), '0, '0);
      step();
    end
    idle();
    repeat (4) step();
    check("burst_rd_acks", BW'(resp_cnt - r0), BW'(8));

    // Reset in the middle of traffic with a write pending must not commit it.
    rst_n = 1'b0;
    req(1'b1, 24'd3, {SW{8'hEE}}, {SW{1'b1}});
    repeat (3) step();
    rst_n = 1'b1;
    idle();
    repeat (2) step();
    xact(1'b0, 24'd3, '0, '0);
    check("reset_no_write", seen_data, {SW{8'h03}});

    // Directed table: byte lanes, range errors, edge addresses.
    for (int i = 0; i < 10; i++) begin
      xact(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel);
      check($sformatf("tbl%0d_err", i), BW'(seen_err), BW'(tbl[i].exp_err));
      check($sformatf("tbl%0d_ack", i), BW'(seen_ack), BW'(!tbl[i].exp_err));
      if (tbl[i].chk_data) check($sformatf("tbl%0d_data", i), seen_data, tbl[i].exp_data);
    end

    // Abort: two reads accepted, then cyc drops; no response may surface.
    r0 = resp_cnt;
    req(1'b0, 24'd1, '0, '0);
    step();
    req(1'b0, 24'd2, '0, '0);
    step();
    bus.cyc = 1'b0; bus.stb = 1'b0;
    repeat (5) step();
    check("abort_no_resp", BW'(resp_cnt - r0), BW'(0));
    xact(1'b0, 24'd1, '0, '0);
    check("post_abort_ack", BW'(seen_ack), BW'(1'b1));
    check("post_abort_data", seen_data, {SW{8'h01}});

    // Read-after-write on consecutive cycles.
    req(1'b1, 24'd9, {16{32'hC0DE_0009}}, {SW{1'b1}});
    step();
    req(1'b0, 24'd9, '0, '0);
    step();
    idle();
    repeat (4) step();

    // Fill a small window fully so random reads have known contents.
    for (int a = 0; a < 16; a++) begin
      req(1'b1, AW'(a), rand_word(), {SW{1'b1}});
      step();
    end
    idle();
    repeat (4) step();

    // Randomized mixed traffic with pseudo-random backpressure.
    r0 = resp_cnt;
    a0 = acc_cnt;
    accepted = 0;
    pending  = 1'b0;
    rw = '0; rwe = 1'b0; ra = '0; rs = '0;
    while (accepted < 200) begin
      if (!pending) begin
        rwe = 1'(($urandom & 1));
        ra  = ($urandom_range(0, 9) == 0) ? AW'(1024 + $urandom_range(0, 4000)) : AW'($urandom_range(0, 15));
        rw  = rand_word();
        rs  = {$urandom, $urandom};
        pending = 1'b1;
      end
      req(rwe, ra, rw, rs);
      bus.hold = ($urandom_range(0, 3) == 0);
      if (!bus.hold) begin
        accepted++;
        pending = 1'b0;
      end
      step();
    end
    idle();
    repeat (5) step();
    check("rand_accepts", BW'(acc_cnt - a0), BW'(200));
    check("rand_resp_count", BW'(resp_cnt - r0), BW'(acc_cnt - a0));
    check("queue_drained", BW'(q.size()), BW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
